// File: rtl/video_timing.sv
// video_timing: free-running raster counter driving pixel coordinates to the pixel
// source and a sync vector delayed to line up with the source's rgb output.
module video_timing #(
   parameter int   H_ACTIVE = 640,
   parameter int   H_FP     = 16,
   parameter int   H_SYNC   = 96,
   parameter int   H_BP     = 48,
   parameter int   V_ACTIVE = 480,
   parameter int   V_FP     = 10,
   parameter int   V_SYNC   = 2,
   parameter int   V_BP     = 33,
   parameter logic H_POL    = 1'b0,
   parameter logic V_POL    = 1'b0,
   parameter int   LATENCY  = 2
) (
   input  logic        hdmi_clk,
   input  logic        reset,
   output logic [10:0] pix_x,
   output logic [9:0]  pix_y,
   output logic        pix_valid,
   output logic        line_start,
   output logic        frame_start,
   output logic [2:0]  hve_sync
);
   localparam logic [10:0] H_A  = 11'(H_ACTIVE);
   localparam logic [10:0] H_S0 = 11'(H_ACTIVE + H_FP);
   localparam logic [10:0] H_S1 = 11'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [10:0] H_L  = 11'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
   localparam logic [9:0]  V_A  = 10'(V_ACTIVE);
   localparam logic [9:0]  V_S0 = 10'(V_ACTIVE + V_FP);
   localparam logic [9:0]  V_S1 = 10'(V_ACTIVE + V_FP + V_SYNC);
   localparam logic [9:0]  V_L  = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
   localparam logic [2:0]  SYNC_RST = {1'b0, ~V_POL, ~H_POL};

   logic [10:0] h_q, h_d, pix_x_q, pix_x_d;
   logic [9:0]  v_q, v_d, pix_y_q, pix_y_d;
   logic        pix_valid_q, pix_valid_d, line_start_q, line_start_d, frame_start_q, frame_start_d;
   // sync_q[0] is registered alongside pix_*, each further stage adds one cycle
   logic [2:0]  sync_q [LATENCY+1];
   logic [2:0]  sync_d [LATENCY+1];

   always_comb begin
      h_d           = (h_q == H_L) ? '0 : h_q + 11'd1;
      v_d           = (h_q != H_L) ? v_q : (v_q == V_L) ? '0 : v_q + 10'd1;
      pix_x_d       = (h_q < H_A) ? h_q : '0;
      pix_y_d       = (v_q < V_A) ? v_q : '0;
      pix_valid_d   = (h_q < H_A) && (v_q < V_A);
      line_start_d  = h_q == '0;
      frame_start_d = (h_q == '0) && (v_q == '0);
      sync_d[0]     = {pix_valid_d,
                       (v_q >= V_S0 && v_q < V_S1) ? V_POL : ~V_POL,
                       (h_q >= H_S0 && h_q < H_S1) ? H_POL : ~H_POL};
      for (int i = 1; i <= LATENCY; i++) sync_d[i] = sync_q[i-1];
   end

   always_ff @(posedge hdmi_clk or posedge reset) begin
      if (reset) begin
         h_q           <= '0;
         v_q           <= '0;
         pix_x_q       <= '0;
         pix_y_q       <= '0;
         pix_valid_q   <= 1'b0;
         line_start_q  <= 1'b0;
         frame_start_q <= 1'b0;
         for (int i = 0; i <= LATENCY; i++) sync_q[i] <= SYNC_RST;
      end else begin
         h_q           <= h_d;
         v_q           <= v_d;
         pix_x_q       <= pix_x_d;
         pix_y_q       <= pix_y_d;
         pix_valid_q   <= pix_valid_d;
         line_start_q  <= line_start_d;
         frame_start_q <= frame_start_d;
         for (int i = 0; i <= LATENCY; i++) sync_q[i] <= sync_d[i];
      end
   end

   assign pix_x       = pix_x_q;
   assign pix_y       = pix_y_q;
   assign pix_valid   = pix_valid_q;
   assign line_start  = line_start_q;
   assign frame_start = frame_start_q;
   assign hve_sync    = sync_q[LATENCY];
endmodule

// File: tb/tb_video_timing.sv
// tb_video_timing: scoreboard bench for three video_timing instances
// (640x480 default, a small raster at LATENCY=2, and a small raster at LATENCY=0 with inverted polarities).
module tb_video_timing;
   typedef struct packed {
      logic [10:0] x;
      logic [9:0]  y;
      logic        valid;
      logic        ls;
      logic        fs;
      logic [2:0]  sync;
   } vt_t;

   logic hdmi_clk = 1'b0;
   logic reset = 1'b1;
   int   n = 0;
   int   checks = 0;
   int   passes = 0;
   vt_t  q0[$], q1[$], q2[$];

   logic [10:0] x0, x1, x2;
   logic [9:0]  y0, y1, y2;
   logic        pv0, pv1, pv2, ls0, ls1, ls2, fs0, fs1, fs2;
   logic [2:0]  s0, s1, s2;
   vt_t         g0, g1, g2;

   always #5 hdmi_clk = ~hdmi_clk;

   video_timing d0 (.hdmi_clk(hdmi_clk), .reset(reset), .pix_x(x0), .pix_y(y0), .pix_valid(pv0),
                    .line_start(ls0), .frame_start(fs0), .hve_sync(s0));
   video_timing #(.H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(4), .V_ACTIVE(8), .V_FP(2), .V_SYNC(2),
                  .V_BP(3), .LATENCY(2))
      d1 (.hdmi_clk(hdmi_clk), .reset(reset), .pix_x(x1), .pix_y(y1), .pix_valid(pv1),
          .line_start(ls1), .frame_start(fs1), .hve_sync(s1));
   video_timing #(.H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(4), .V_ACTIVE(8), .V_FP(2), .V_SYNC(2),
                  .V_BP(3), .H_POL(1'b1), .V_POL(1'b1), .LATENCY(0))
      d2 (.hdmi_clk(hdmi_clk), .reset(reset), .pix_x(x2), .pix_y(y2), .pix_valid(pv2),
          .line_start(ls2), .frame_start(fs2), .hve_sync(s2));

   assign g0 = {x0, y0, pv0, ls0, fs0, s0};
   assign g1 = {x1, y1, pv1, ls1, fs1, s1};
   assign g2 = {x2, y2, pv2, ls2, fs2, s2};

   // closed-form expectation for the n-th edge after reset release
   function automatic vt_t model(int ha, int hf, int hs, int hb, int va, int vf, int vs, int vb,
                                 logic hp, logic vp, int lat, int k);
      int ht = ha + hf + hs + hb;
      int vt = va + vf + vs + vb;
      int h = k % ht;
      int v = (k / ht) % vt;
      int m = k - lat;
      int hm, vm;
      vt_t r;
      r.x     = (h < ha) ? 11'(h) : 11'd0;
      r.y     = (v < va) ? 10'(v) : 10'd0;
      r.valid = (h < ha) && (v < va);
      r.ls    = h == 0;
      r.fs    = (h == 0) && (v == 0);
      if (m < 0) r.sync = {1'b0, ~vp, ~hp};
      else begin
         hm = m % ht;
         vm = (m / ht) % vt;
         r.sync = {(hm < ha) && (vm < va),
                   (vm >= va + vf && vm < va + vf + vs) ? vp : ~vp,
                   (hm >= ha + hf && hm < ha + hf + hs) ? hp : ~hp};
      end
      return r;
   endfunction

   task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
      checks++;
      if (got === exp) passes++;
      else $display("FAIL %s at %0t: got %0h, want %0h", tag, $time, got, exp);
   endtask

   task automatic cmp(string d, vt_t g, vt_t e);
      chk({d, ".pix_x"}, 32'(g.x), 32'(e.x));
      chk({d, ".pix_y"}, 32'(g.y), 32'(e.y));
      chk({d, ".pix_valid"}, 32'(g.valid), 32'(e.valid));
      chk({d, ".line_start"}, 32'(g.ls), 32'(e.ls));
      chk({d, ".frame_start"}, 32'(g.fs), 32'(e.fs));
      chk({d, ".hve_sync"}, 32'(g.sync), 32'(e.sync));
   endtask

   task automatic check_reset(string tag);
      cmp({tag, ".d0"}, g0, {11'd0, 10'd0, 1'b0, 1'b0, 1'b0, 3'b011});
      cmp({tag, ".d1"}, g1, {11'd0, 10'd0, 1'b0, 1'b0, 1'b0, 3'b011});
      cmp({tag, ".d2"}, g2, {11'd0, 10'd0, 1'b0, 1'b0, 1'b0, 3'b000});
   endtask

   always @(posedge hdmi_clk or posedge reset) begin
      if (reset) n <= 0;
      else begin
         q0.push_back(model(640, 16, 96, 48, 480, 10, 2, 33, 1'b0, 1'b0, 2, n));
         q1.push_back(model(16, 2, 3, 4, 8, 2, 2, 3, 1'b0, 1'b0, 2, n));
         q2.push_back(model(16, 2, 3, 4, 8, 2, 2, 3, 1'b1, 1'b1, 0, n));
         n <= n + 1;
      end
   end

   always @(negedge hdmi_clk) begin
      if (!reset && q0.size() > 0) begin
         cmp("d0", g0, q0.pop_front());
         cmp("d1", g1, q1.pop_front());
         cmp("d2", g2, q2.pop_front());
      end
   end

   initial begin
      repeat (3) @(negedge hdmi_clk);
      check_reset("por");
      #2 reset = 1'b0;
      repeat (1900) @(negedge hdmi_clk);
      #2 reset = 1'b1;
      #1 check_reset("async");
      repeat (5) @(posedge hdmi_clk);
      @(negedge hdmi_clk);
      check_reset("held");
      #2 reset = 1'b0;
      repeat (2000) @(negedge hdmi_clk);
      #1 $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end
endmodule
